// File: rtl/perf_pkg.sv
// perf_pkg: items shared by the performance-counter UART reporter.
//   MSG_LEN      - bytes per report line ("C=" + 8 hex digits + CR LF)
//   state_t      - control FSM states of perf_uart_tx
//   hex_to_ascii - 4-bit value to uppercase ASCII hex digit
package perf_pkg;

    localparam int unsigned MSG_LEN = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_t;

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        // 'A' (0x41) minus 10 gives the base for digits A-F
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer with a ready/valid handshake.
//   CLK_50     in   system clock
//   resetN     in   asynchronous active-low reset
//   data[7:0]  in   byte to send, taken when valid & ready
//   valid      in   data is presented
//   ready      out  serializer can take a byte this cycle
//   tx         out  serial line, idle high
//   frame_done out  one-cycle pulse in the final cycle of the stop bit
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       CLK_50,
    input  logic       resetN,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       frame_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0] BIT_LAST_DATA = 4'd8;
    localparam logic [3:0] BIT_STOP      = 4'd9;

    logic             active;
    logic [7:0]       shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic [3:0]       bit_idx;   // 0 = start, 1..8 = data, 9 = stop
    logic             bit_end;
    logic             accept;

    assign bit_end    = active && (bit_cnt == CNT_LAST);
    assign frame_done = bit_end && (bit_idx == BIT_STOP);
    // The last stop-bit cycle counts as idle so a following byte starts
    // on the very next cycle with no gap on the line.
    assign ready      = !active || frame_done;
    assign accept     = valid && ready;

    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            active  <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else if (accept) begin
            active  <= 1'b1;
            shreg   <= data;
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= 1'b0;
        end else if (active) begin
            if (bit_end) begin
                bit_cnt <= '0;
                if (bit_idx == BIT_STOP) begin
                    active  <= 1'b0;
                    bit_idx <= '0;
                    tx      <= 1'b1;
                end else if (bit_idx == BIT_LAST_DATA) begin
                    bit_idx <= bit_idx + 4'd1;
                    tx      <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    tx      <= shreg[0];
                    shreg   <= {1'b0, shreg[7:1]};
                end
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/perf_uart_tx.sv
// perf_uart_tx: on a rising edge of `finished`, snapshots cycle_count and
// sends "C=XXXXXXXX\r\n" (uppercase hex, MSB nibble first) over 8N1 UART.
//   CLK_50       in   system clock
//   resetN       in   asynchronous active-low reset
//   finished     in   level; 0->1 starts one report
//   cycle_count  in   live 32-bit count, sampled at the trigger only
//   uart_tx      out  serial line, idle high
//   busy         out  report in progress
//   done         out  report complete, held until finished falls
module perf_uart_tx
    import perf_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD         = 115_200,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic        CLK_50,
    input  logic        resetN,
    input  logic        finished,
    input  logic [31:0] cycle_count,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

    state_t      state;
    logic        finished_d;
    logic [31:0] snapshot;
    logic [3:0]  byte_idx;
    logic [3:0]  next_idx;
    logic [3:0]  sel_idx;
    logic [7:0]  cur_byte;
    logic        trigger;
    logic        ser_valid;
    logic        ser_ready;
    logic        frame_done;

    assign trigger  = finished && !finished_d && (state == ST_IDLE);
    assign next_idx = byte_idx + 4'd1;
    assign busy     = (state == ST_SEND) || (state == ST_WAIT);
    assign done     = (state == ST_DONE);

    // Bytes after the first are handed over in WAIT on the frame_done cycle,
    // so the mux looks one byte ahead there; SEND is only used for byte 0.
    assign sel_idx   = (state == ST_WAIT) ? next_idx : byte_idx;
    assign ser_valid = (state == ST_SEND) ||
                       ((state == ST_WAIT) && frame_done && (byte_idx != LAST_IDX));

    always_comb begin
        cur_byte = '0;
        case (sel_idx)
            4'd0:    cur_byte = 8'h43;
            4'd1:    cur_byte = 8'h3D;
            4'd2:    cur_byte = hex_to_ascii(snapshot[31:28]);
            4'd3:    cur_byte = hex_to_ascii(snapshot[27:24]);
            4'd4:    cur_byte = hex_to_ascii(snapshot[23:20]);
            4'd5:    cur_byte = hex_to_ascii(snapshot[19:16]);
            4'd6:    cur_byte = hex_to_ascii(snapshot[15:12]);
            4'd7:    cur_byte = hex_to_ascii(snapshot[11:8]);
            4'd8:    cur_byte = hex_to_ascii(snapshot[7:4]);
            4'd9:    cur_byte = hex_to_ascii(snapshot[3:0]);
            4'd10:   cur_byte = 8'h0D;
            4'd11:   cur_byte = 8'h0A;
            default: cur_byte = '0;
        endcase
    end

    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            finished_d <= 1'b0;
        end else begin
            finished_d <= finished;
        end
    end

    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            state    <= ST_IDLE;
            snapshot <= '0;
            byte_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        snapshot <= cycle_count;
                        byte_idx <= '0;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (ser_ready) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (frame_done) begin
                        if (byte_idx == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            byte_idx <= next_idx;
                        end
                    end
                end
                ST_DONE: begin
                    if (!finished) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .CLK_50    (CLK_50),
        .resetN    (resetN),
        .data      (cur_byte),
        .valid     (ser_valid),
        .ready     (ser_ready),
        .tx        (uart_tx),
        .frame_done(frame_done)
    );

endmodule

// File: tb/tb_perf_uart_tx.sv
// Bench for perf_uart_tx: a fast-baud instance checked every cycle against a
// timestamp-based waveform model, plus a default-rate instance with literal
// bit-timing checks.
module tb_perf_uart_tx;

    localparam int unsigned N       = 10;        // 50 MHz / 5 Mbaud
    localparam int unsigned MSG_CYC = 120 * N;

    logic        CLK_50 = 1'b0;
    logic        resetN = 1'b0;
    logic        finished = 1'b0;
    logic [31:0] cycle_count = '0;
    logic        uart_tx, busy, done;

    logic        finished2 = 1'b0;
    logic [31:0] cycle_count2 = '0;
    logic        tx2, busy2, done2;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;

    always #10 CLK_50 = ~CLK_50;

    perf_uart_tx #(
        .CLK_FREQ(50_000_000),
        .BAUD    (5_000_000)
    ) dut (
        .CLK_50     (CLK_50),
        .resetN     (resetN),
        .finished   (finished),
        .cycle_count(cycle_count),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .done       (done)
    );

    perf_uart_tx dut_def (
        .CLK_50     (CLK_50),
        .resetN     (resetN),
        .finished   (finished2),
        .cycle_count(cycle_count2),
        .uart_tx    (tx2),
        .busy       (busy2),
        .done       (done2)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] asc(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h41 + ({4'h0, n} - 8'd10);
    endfunction

    // ---------------- waveform model ----------------
    // phase 0: idle, 1: report in flight since trigger cycle t0, 2: done
    int          phase = 0;
    logic        fd_m = 1'b0;
    int unsigned cyc = 0;
    int unsigned t0 = 0;
    logic [7:0]  msg_m [12];

    always @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            phase <= 0;
            fd_m  <= 1'b0;
        end else begin
            case (phase)
                0: if (finished && !fd_m) begin
                    t0 <= cyc;
                    msg_m[0]  <= 8'h43;
                    msg_m[1]  <= 8'h3D;
                    for (int i = 0; i < 8; i++) msg_m[2+i] <= asc(cycle_count[28-4*i +: 4]);
                    msg_m[10] <= 8'h0D;
                    msg_m[11] <= 8'h0A;
                    phase <= 1;
                end
                1: if (cyc == t0 + 1 + MSG_CYC) phase <= 2;
                2: if (!finished) phase <= 0;
                default: phase <= 0;
            endcase
            fd_m <= finished;
            cyc  <= cyc + 1;
        end
    end

    function automatic logic exp_tx();
        int j, b, p;
        if (phase != 1) return 1'b1;
        j = int'(cyc - t0) - 2;
        if (j < 0 || j >= int'(MSG_CYC)) return 1'b1;
        b = j / int'(10 * N);
        p = (j % int'(10 * N)) / int'(N);
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return msg_m[b][p-1];
    endfunction

    always @(negedge CLK_50) begin
        chk("uart_tx", {31'b0, uart_tx}, {31'b0, exp_tx()});
        chk("busy", {31'b0, busy}, {31'b0, (phase == 1)});
        chk("done", {31'b0, done}, {31'b0, (phase == 2)});
    end

    // ---------------- line receiver ----------------
    logic        rx_busy = 1'b0;
    int unsigned rx_t = 0;
    logic [7:0]  rx_sh = '0;
    logic [7:0]  rx_q [$];

    always @(negedge CLK_50) begin
        if (!resetN) begin
            rx_busy <= 1'b0;
            rx_q.delete();
        end else if (!rx_busy) begin
            if (uart_tx == 1'b0) begin
                rx_busy <= 1'b1;
                rx_t    <= 1;
            end
        end else begin
            if ((rx_t % N) == N / 2 && rx_t / N >= 1 && rx_t / N <= 8)
                rx_sh <= {uart_tx, rx_sh[7:1]};
            if (rx_t == 9 * N + N / 2) begin
                rx_busy <= 1'b0;
                rx_q.push_back(rx_sh);
            end
            rx_t <= rx_t + 1;
        end
    end

    task automatic check_msg(input string name, input string txt);
        string exp_s, got_h, exp_h;
        logic  ok;
        exp_s = {txt, "\r\n"};
        ok = (rx_q.size() == exp_s.len());
        got_h = "";
        exp_h = "";
        foreach (rx_q[i]) got_h = {got_h, $sformatf("%02h ", rx_q[i])};
        for (int i = 0; i < exp_s.len(); i++) begin
            exp_h = {exp_h, $sformatf("%02h ", exp_s[i])};
            if (ok && rx_q[i] !== exp_s[i]) ok = 1'b0;
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got bytes %s expected %s", name, got_h, exp_h);
        end
        rx_q.delete();
    endtask

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(posedge CLK_50);
        #1;
    endtask

    task automatic fire(input logic [31:0] cnt);
        @(posedge CLK_50);
        #1;
        cycle_count = cnt;
        finished    = 1'b1;
    endtask

    int unsigned at;
    task automatic step_to(input int unsigned off);
        while (at < off) begin
            @(negedge CLK_50);
            at++;
        end
    endtask

    initial begin
        // reset values
        wait_cyc(3);
        @(negedge CLK_50);
        chk("rst_tx", {31'b0, uart_tx}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_tx_def", {31'b0, tx2}, 32'd1);
        @(posedge CLK_50);
        #1 resetN = 1'b1;
        wait_cyc(2);

        // default-rate instance: 434 cycles per bit, 52080 per message
        cycle_count2 = 32'h0000ABCD;
        finished2    = 1'b1;            // cycle T
        @(negedge CLK_50);
        at = 0;
        chk("def_busy_T", {31'b0, busy2}, 32'd0);
        step_to(1);
        chk("def_busy_T1", {31'b0, busy2}, 32'd1);
        chk("def_tx_T1", {31'b0, tx2}, 32'd1);
        step_to(2);
        chk("def_start_first", {31'b0, tx2}, 32'd0);
        step_to(435);
        chk("def_start_last", {31'b0, tx2}, 32'd0);
        step_to(436);
        chk("def_bit0", {31'b0, tx2}, 32'd1);
        step_to(870);
        chk("def_bit1", {31'b0, tx2}, 32'd1);
        step_to(1304);
        chk("def_bit2", {31'b0, tx2}, 32'd0);
        step_to(4341);
        chk("def_stop0_end", {31'b0, tx2}, 32'd1);
        step_to(4342);
        chk("def_start1_nogap", {31'b0, tx2}, 32'd0);
        step_to(52081);
        chk("def_busy_end", {31'b0, busy2}, 32'd1);
        chk("def_done_early", {31'b0, done2}, 32'd0);
        step_to(52082);
        chk("def_busy_fall", {31'b0, busy2}, 32'd0);
        chk("def_done_rise", {31'b0, done2}, 32'd1);
        wait_cyc(1);
        finished2 = 1'b0;
        wait_cyc(3);
        chk("def_done_clear", {31'b0, done2}, 32'd0);

        // basic message
        fire(32'h0000ABCD);
        wait_cyc(MSG_CYC + 10);
        chk("basic_done", {31'b0, done}, 32'd1);
        chk("basic_busy", {31'b0, busy}, 32'd0);
        check_msg("basic_msg", "C=0000ABCD");
        finished = 1'b0;
        wait_cyc(3);
        chk("done_clear", {31'b0, done}, 32'd0);

        // snapshot: count moves during transmission; pulse on finished ignored
        fire(32'hDEADBEEF);
        for (int i = 0; i < int'(MSG_CYC) + 10; i++) begin
            @(posedge CLK_50);
            #1;
            cycle_count = cycle_count + 32'd1;
            if (i == 300) finished = 1'b0;
            if (i == 305) finished = 1'b1;
        end
        check_msg("snap_msg", "C=DEADBEEF");
        wait_cyc(MSG_CYC + 100);
        chk("held_one_msg", rx_q.size(), 32'd0);
        chk("held_done", {31'b0, done}, 32'd1);

        // retrigger after done
        finished = 1'b0;
        wait_cyc(3);
        fire(32'h00000010);
        wait_cyc(MSG_CYC + 10);
        check_msg("retrig_msg", "C=00000010");
        finished = 1'b0;
        wait_cyc(3);

        // hex extremes
        fire(32'h00000000);
        wait_cyc(MSG_CYC + 10);
        check_msg("zero_msg", "C=00000000");
        finished = 1'b0;
        wait_cyc(3);
        fire(32'hFFFFFFFF);
        wait_cyc(MSG_CYC + 10);
        check_msg("ones_msg", "C=FFFFFFFF");
        finished = 1'b0;
        wait_cyc(3);

        // reset during byte 5 (line low on data bit 1 of '4')
        fire(32'h12345678);
        wait_cyc(2 + 5 * 10 * N + 25);
        chk("pre_rst_tx", {31'b0, uart_tx}, 32'd0);
        @(negedge CLK_50);
        #2 resetN = 1'b0;
        #1;
        chk("mid_rst_tx", {31'b0, uart_tx}, 32'd1);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        cycle_count = 32'hCAFE0001;
        wait_cyc(3);
        resetN = 1'b1;
        wait_cyc(MSG_CYC + 10);
        check_msg("post_rst_msg", "C=CAFE0001");
        wait_cyc(200);
        chk("post_rst_one_msg", rx_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
